// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl: PS/2 make/break/E0 sequencer with held-key tracking, press counter and event FIFO (option: TYPEMATIC_PASS_EN)
module ps2_key_event_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_break,
  output logic             ev_ext,
  output logic             held_valid,
  output logic [7:0]       held_code,
  output logic             held_ext,
  output logic [CNT_W-1:0] press_cnt,
  output logic             overflow,
  input  logic             clear_ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;
  state_t state_q, state_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [9:0] mem_q [FIFO_DEPTH];
  logic [9:0] mem_d [FIFO_DEPTH];
  logic held_valid_q, held_valid_d, held_ext_q, held_ext_d, overflow_q, overflow_d;
  logic [7:0] held_code_q, held_code_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic make, brk, ext, pfx, match, fresh, push, pop, full, accept, drop;
  // prefix protocol: classify each received byte as make, break or prefix/discard
  always_comb begin
    state_d = state_q;
    make = 1'b0;
    brk = 1'b0;
    ext = 1'b0;
    pfx = rx_data == 8'hE0 || rx_data == 8'hF0;
    if (rx_valid) begin
      if (rx_data == 8'h00 || rx_data == 8'hFF) state_d = S_IDLE;
      else case (state_q)
        S_IDLE: begin
          state_d = rx_data == 8'hE0 ? S_EXT : rx_data == 8'hF0 ? S_BRK : S_IDLE;
          make = !pfx;
        end
        S_EXT: begin
          state_d = rx_data == 8'hF0 ? S_EXT_BRK : rx_data == 8'hE0 ? S_EXT : S_IDLE;
          make = !pfx;
          ext = 1'b1;
        end
        S_BRK: begin
          state_d = S_IDLE;
          brk = !pfx;
        end
        S_EXT_BRK: begin
          state_d = S_IDLE;
          brk = !pfx;
          ext = 1'b1;
        end
      endcase
    end
  end
  // held key, press counter, overflow flag and FIFO pointer/storage updates
  always_comb begin
    match = held_valid_q && held_ext_q == ext && held_code_q == rx_data;
    fresh = make && !match;
`ifdef TYPEMATIC_PASS_EN
    push = brk || make;
`else
    push = brk || fresh;
`endif
    full = wr_q[AW] != rd_q[AW] && wr_q[AW-1:0] == rd_q[AW-1:0];
    pop = ev_valid && ev_ready;
    accept = push && (!full || pop);
    drop = push && full && !pop;
    wr_d = wr_q + {{AW{1'b0}}, accept};
    rd_d = rd_q + {{AW{1'b0}}, pop};
    mem_d = mem_q;
    if (accept) mem_d[wr_q[AW-1:0]] = {rx_data, brk, ext};
    held_valid_d = fresh ? 1'b1 : (brk && match) ? 1'b0 : held_valid_q;
    held_code_d = fresh ? rx_data : held_code_q;
    held_ext_d = fresh ? ext : held_ext_q;
    press_cnt_d = press_cnt_q + {{(CNT_W-1){1'b0}}, fresh};
    overflow_d = drop || (overflow_q && !clear_ovf);
  end
  // state and control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      wr_q <= '0;
      rd_q <= '0;
      held_valid_q <= 1'b0;
      held_code_q <= '0;
      held_ext_q <= 1'b0;
      press_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      held_valid_q <= held_valid_d;
      held_code_q <= held_code_d;
      held_ext_q <= held_ext_d;
      press_cnt_q <= press_cnt_d;
      overflow_q <= overflow_d;
    end
  end
  // FIFO storage; stale entries are masked by ev_valid so no reset is needed
  always_ff @(posedge clk) mem_q <= mem_d;
  assign ev_valid = wr_q != rd_q;
  assign {ev_code, ev_break, ev_ext} = ev_valid ? mem_q[rd_q[AW-1:0]] : 10'd0;
  assign held_valid = held_valid_q;
  assign held_code = held_code_q;
  assign held_ext = held_ext_q;
  assign press_cnt = press_cnt_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// tb_ps2_key_event_ctrl: directed self-checking bench for ps2_key_event_ctrl
module tb_ps2_key_event_ctrl;
  logic clk = 1'b0, resetn = 1'b0, rx_valid = 1'b0, ev_ready = 1'b0, clear_ovf = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic ev_valid, ev_break, ev_ext, held_valid, held_ext, overflow;
  logic [7:0] ev_code, held_code, press_cnt;
  int errors = 0, checks = 0;
  logic [9:0] got [$];
  ps2_key_event_ctrl #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_break(ev_break),
    .ev_ext(ev_ext), .held_valid(held_valid), .held_code(held_code), .held_ext(held_ext),
    .press_cnt(press_cnt), .overflow(overflow), .clear_ovf(clear_ovf)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (resetn && ev_valid && ev_ready) got.push_back({ev_code, ev_break, ev_ext});
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic expect_ev(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    obs = 10'h3FF;
    if (got.size() != 0) obs = got.pop_front();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    rx_valid = 1'b0;
    ev_ready = 1'b0;
    clear_ovf = 1'b0;
    idle(2);
    resetn = 1'b1;
    got.delete();
  endtask
  initial begin
    idle(3);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_head", {ev_code, ev_break, ev_ext}, 0);
    check("rst_held", {held_valid, held_code, held_ext}, 0);
    check("rst_cnt", press_cnt, 0);
    check("rst_ovf", overflow, 0);
    resetn = 1'b1;
    ev_ready = 1'b1;
    send(8'h1C);
    check("mk_held_valid", held_valid, 1);
    check("mk_held_code", held_code, 8'h1C);
    send(8'hF0);
    send(8'h1C);
    idle(2);
    check("brk_held_valid", held_valid, 0);
    check("brk_cnt", press_cnt, 1);
    expect_ev("ev1_make", {8'h1C, 1'b0, 1'b0});
    expect_ev("ev1_break", {8'h1C, 1'b1, 1'b0});
    check("ev1_count", got.size(), 0);
    do_reset();
    ev_ready = 1'b1;
    send(8'h1C);
    send(8'h1C);
    send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    idle(2);
    check("rep_cnt", press_cnt, 1);
    expect_ev("rep_make", {8'h1C, 1'b0, 1'b0});
`ifdef TYPEMATIC_PASS_EN
    expect_ev("rep_make2", {8'h1C, 1'b0, 1'b0});
    expect_ev("rep_make3", {8'h1C, 1'b0, 1'b0});
`endif
    expect_ev("rep_break", {8'h1C, 1'b1, 1'b0});
    check("rep_count", got.size(), 0);
    do_reset();
    ev_ready = 1'b1;
    send(8'hE0);
    send(8'h75);
    check("ext_held", {held_valid, held_code, held_ext}, {1'b1, 8'h75, 1'b1});
    send(8'hF0);
    send(8'h75);
    check("ext_nonext_brk_held", held_valid, 1);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    idle(2);
    check("ext_brk_held", held_valid, 0);
    expect_ev("ext_make", {8'h75, 1'b0, 1'b1});
    expect_ev("ext_nonext_brk", {8'h75, 1'b1, 1'b0});
    expect_ev("ext_brk", {8'h75, 1'b1, 1'b1});
    do_reset();
    send(8'h15);
    send(8'h16);
    send(8'h1C);
    send(8'h1D);
    check("full_no_ovf", overflow, 0);
    send(8'h24);
    check("ovf_set", overflow, 1);
    check("ovf_cnt", press_cnt, 5);
    check("ovf_held_code", held_code, 8'h24);
    check("ovf_head", {ev_valid, ev_code, ev_break, ev_ext}, {1'b1, 8'h15, 2'b00});
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = 8'h2B;
    clear_ovf = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    clear_ovf = 1'b0;
    check("drop_beats_clear", overflow, 1);
    check("drop_cnt", press_cnt, 6);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);
    ev_ready = 1'b1;
    idle(6);
    ev_ready = 1'b0;
    expect_ev("drain0", {8'h15, 2'b00});
    expect_ev("drain1", {8'h16, 2'b00});
    expect_ev("drain2", {8'h1C, 2'b00});
    expect_ev("drain3", {8'h1D, 2'b00});
    check("drain_empty", {ev_valid, 8'(got.size())}, 0);
    do_reset();
    send(8'h15);
    send(8'h16);
    send(8'h1C);
    send(8'h1D);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = 8'h24;
    ev_ready = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    ev_ready = 1'b0;
    check("pushpop_no_ovf", overflow, 0);
    check("pushpop_head", ev_code, 8'h16);
    ev_ready = 1'b1;
    idle(6);
    ev_ready = 1'b0;
    expect_ev("pp0", {8'h15, 2'b00});
    expect_ev("pp1", {8'h16, 2'b00});
    expect_ev("pp2", {8'h1C, 2'b00});
    expect_ev("pp3", {8'h1D, 2'b00});
    expect_ev("pp4", {8'h24, 2'b00});
    do_reset();
    send(8'hE0);
    send(8'hF0);
    do_reset();
    ev_ready = 1'b1;
    send(8'h1C);
    idle(2);
    check("midrst_cnt", press_cnt, 1);
    expect_ev("midrst_make", {8'h1C, 2'b00});
    do_reset();
    ev_ready = 1'b1;
    send(8'hE0);
    send(8'h00);
    send(8'h1C);
    idle(2);
    check("zero_held_ext", {held_valid, held_ext}, 2'b10);
    expect_ev("zero_make", {8'h1C, 2'b00});
    check("zero_count", got.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
